dp_sequencer: RTL and testbench
===============================

Name: dp_sequencer

Overview:
- Sequencing controller for the 9-bit-instruction, 8-bit datapath.
- Starts a program run on request, holds the datapath in initialisation, then decodes each fetched opcode/fcode into datapath control strobes.
- Inserts a stall cycle for memory loads, detects program end, and bounds run length with a watchdog.
- Sits between top-level test harness handshake (go/done) and the datapath control inputs.

Parameters:
- INIT_CYCLES, 2, number of cycles dp_start is held high before execution begins (min 1).
- MAX_CYCLES, 16'hFFFF, watchdog limit on executed cycles per run.
- CNT_W, 16, width of cycle_count.

Ports:
- CLK  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-low reset (0 = reset)
- go  in  1  run request from harness; a run starts on a 0->1 edge
- opcode  in  4  instruction bits [8:5] from datapath
- fcode  in  1  instruction bit [0] from datapath
- dp_done  in  1  end-of-program indication from the datapath fetch unit
- dp_start  out  1  datapath init/reset strobe
- branch_rel_z, branch_rel_nz, branch_abs  out  1 each  branch selects
- reg_write_en, reg_sel, lut_in, mem_to_reg, alu_src, alu_sc_in, read_mem, write_mem  out  1 each  datapath controls
- alu_op  out  3  ALU operation
- pc_hold  out  1  freezes PC (stall)
- busy  out  1  run in progress
- done  out  1  run finished (level)
- timeout  out  1  run ended by watchdog
- cycle_count  out  CNT_W  executed cycles in current/last run

Behaviour:
- FSM states: IDLE, INIT, EXEC, LOAD2, FINISH.
- Reset (reset=0 at clock edge):
  - state=IDLE; dp_start=1; busy=0; done=0; timeout=0; cycle_count=0; go edge register=0.
  - A reset mid-run aborts immediately with the same values.
- IDLE:
  - All strobes 0; pc_hold=1; dp_start=1.
  - go rising edge -> INIT; cycle_count cleared.
- INIT:
  - dp_start=1 for exactly INIT_CYCLES cycles, counted by an init counter; pc_hold=1.
  - Then -> EXEC; busy=1 from the first INIT cycle.
- EXEC:
  - dp_start=0. Strobes decoded combinationally from opcode/fcode (Mealy); unlisted strobes are 0.
  - 0 ADD: alu_op=0, reg_write_en.
  - 1 ADDI: alu_op=0, alu_src, reg_write_en.
  - 2 SUB: alu_op=1, reg_write_en.
  - 3 AND: alu_op=2, reg_write_en.
  - 4 OR: alu_op=3, reg_write_en.
  - 5 SHL: alu_op=4, alu_sc_in=fcode, reg_write_en.
  - 6 SHR: alu_op=5, alu_sc_in=fcode, reg_write_en.
  - 7 CMP: alu_op=1, no write.
  - 8 LW: read_mem=1, pc_hold=1, reg_write_en=0 -> LOAD2.
  - 9 SW: write_mem.
  - A BZ: branch_rel_z.
  - B BNZ: branch_rel_nz.
  - C JMP: branch_abs, lut_in=fcode.
  - D LDF: reg_sel, reg_write_en.
  - E NOP.
  - F HALT: if fcode=1 -> FINISH with pc_hold=1; if fcode=0, treat as NOP.
- LOAD2:
  - read_mem=1, mem_to_reg=1, reg_write_en=1, pc_hold=0 -> EXEC.
  - A load therefore costs 2 cycles.
- cycle_count: increments every EXEC and LOAD2 cycle, saturating at all-ones.
- Watchdog: if cycle_count==MAX_CYCLES-1 in EXEC/LOAD2, go to FINISH next cycle with timeout=1.
  - The watchdog has priority over instruction decode; that last instruction's strobes are still issued.
- dp_done=1 in EXEC/LOAD2 -> FINISH.
  - In LOAD2, that cycle's strobes are still issued.
  - dp_done is ignored in IDLE/INIT.
- Simultaneous HALT, dp_done and watchdog: FINISH; timeout set only by the watchdog.
- FINISH:
  - All strobes 0; pc_hold=1; busy=0; done=1.
  - cycle_count and timeout frozen.
  - A new go rising edge -> INIT, clearing done, timeout and cycle_count.
- go held high continuously does not restart; only an edge does.

Decomposition:
- Package additions:
  - opcode enum (the 16 values above, 4 bits).
  - ALU op localparams (ADD=0, SUB=1, AND=2, OR=3, SHL=4, SHR=5).
  - FSM state enum.
  - ctrl_t packed struct holding all datapath strobes.
- One sub-module: op_decode, a pure combinational opcode/fcode -> ctrl_t decoder. The FSM gates and overrides its output.

Test Plan:
- Reset, then go pulse with INIT_CYCLES=2 -> dp_start=1 for exactly 2 cycles after the edge, busy=1 from the first INIT cycle, first EXEC cycle has dp_start=0.
- EXEC with opcode=2 -> alu_op=1, reg_write_en=1, pc_hold=0, all other strobes 0; opcode=5 with fcode=1 -> alu_op=4, alu_sc_in=1.
- opcode=8 -> cycle 1: read_mem=1, pc_hold=1, reg_write_en=0; cycle 2: mem_to_reg=1, reg_write_en=1; cycle_count advances by 2.
- 3 NOPs then opcode=F with fcode=1 -> FINISH next cycle, done=1, busy=0, cycle_count=4, timeout=0; opcode=F with fcode=0 -> continues.
- MAX_CYCLES=8 with NOPs forever -> done=1, timeout=1 after the 8th executed cycle, cycle_count=8.
- reset=0 during LOAD2 -> next cycle IDLE, dp_start=1, read_mem=0, done=0; go edge restarts cleanly with cycle_count=0.

Source files
------------

// File: rtl/dp_sequencer_pkg.sv
// Shared types for the datapath sequencer: opcode and FSM enums, ALU
// operation codes and the packed bundle of datapath control strobes.
package dp_sequencer_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_ADDI = 4'h1,
    OP_SUB  = 4'h2,
    OP_AND  = 4'h3,
    OP_OR   = 4'h4,
    OP_SHL  = 4'h5,
    OP_SHR  = 4'h6,
    OP_CMP  = 4'h7,
    OP_LW   = 4'h8,
    OP_SW   = 4'h9,
    OP_BZ   = 4'hA,
    OP_BNZ  = 4'hB,
    OP_JMP  = 4'hC,
    OP_LDF  = 4'hD,
    OP_NOP  = 4'hE,
    OP_HALT = 4'hF
  } opcode_e;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SHL = 3'd4;
  localparam logic [2:0] ALU_SHR = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_INIT   = 3'd1,
    ST_EXEC   = 3'd2,
    ST_LOAD2  = 3'd3,
    ST_FINISH = 3'd4
  } state_e;

  typedef struct packed {
    logic       branch_rel_z;
    logic       branch_rel_nz;
    logic       branch_abs;
    logic       reg_write_en;
    logic       reg_sel;
    logic       lut_in;
    logic       mem_to_reg;
    logic       alu_src;
    logic       alu_sc_in;
    logic       read_mem;
    logic       write_mem;
    logic [2:0] alu_op;
    logic       pc_hold;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

endpackage

// File: rtl/dp_sequencer_op_decode.sv
// Pure combinational instruction decoder.
// Ports:
//   opcode_i  instruction bits [8:5]
//   fcode_i   instruction bit [0]
//   ctrl_o    packed ctrl_t strobe bundle (unlisted strobes are 0)
module dp_sequencer_op_decode
  import dp_sequencer_pkg::*;
(
  input  logic [3:0]        opcode_i,
  input  logic              fcode_i,
  output logic [CTRL_W-1:0] ctrl_o
);

  opcode_e op;
  ctrl_t   c;

  assign op     = opcode_e'(opcode_i);
  assign ctrl_o = c;

  always_comb begin
    c = '0;
    case (op)
      OP_ADD:  begin c.alu_op = ALU_ADD; c.reg_write_en = 1'b1; end
      OP_ADDI: begin c.alu_op = ALU_ADD; c.alu_src = 1'b1; c.reg_write_en = 1'b1; end
      OP_SUB:  begin c.alu_op = ALU_SUB; c.reg_write_en = 1'b1; end
      OP_AND:  begin c.alu_op = ALU_AND; c.reg_write_en = 1'b1; end
      OP_OR:   begin c.alu_op = ALU_OR;  c.reg_write_en = 1'b1; end
      OP_SHL:  begin c.alu_op = ALU_SHL; c.alu_sc_in = fcode_i; c.reg_write_en = 1'b1; end
      OP_SHR:  begin c.alu_op = ALU_SHR; c.alu_sc_in = fcode_i; c.reg_write_en = 1'b1; end
      OP_CMP:  c.alu_op = ALU_SUB;
      // First half of a load: address the memory and freeze the PC so the
      // write-back half can follow in LOAD2.
      OP_LW:   begin c.read_mem = 1'b1; c.pc_hold = 1'b1; end
      OP_SW:   c.write_mem = 1'b1;
      OP_BZ:   c.branch_rel_z = 1'b1;
      OP_BNZ:  c.branch_rel_nz = 1'b1;
      OP_JMP:  begin c.branch_abs = 1'b1; c.lut_in = fcode_i; end
      OP_LDF:  begin c.reg_sel = 1'b1; c.reg_write_en = 1'b1; end
      OP_NOP:  c = '0;
      // fcode=0 is a plain NOP; fcode=1 halts and holds the PC.
      OP_HALT: c.pc_hold = fcode_i;
      default: c = '0;
    endcase
  end

endmodule

// File: rtl/dp_sequencer.sv
// Datapath sequencer: handshakes a run with the harness (go/done), holds the
// datapath in init for INIT_CYCLES, then drives decoded control strobes,
// inserting a stall cycle for loads and bounding run length with a watchdog.
// Ports:
//   CLK, reset (sync, active-low)   clock / reset
//   go                              run request, rising edge starts a run
//   opcode, fcode                   instruction fields from the datapath
//   dp_done                         end-of-program from the fetch unit
//   dp_start                        datapath init strobe
//   branch_*, reg_*, alu_*, mem...  datapath control strobes
//   pc_hold                         PC freeze
//   busy, done, timeout             run status
//   cycle_count                     executed cycles in current/last run
//
// state     | meaning
// ----------+--------------------------------------------------------
// ST_IDLE   | after reset, datapath held in init, waiting for go edge
// ST_INIT   | dp_start held for INIT_CYCLES, run is busy
// ST_EXEC   | decode and issue one instruction per cycle
// ST_LOAD2  | write-back half of a load, PC released
// ST_FINISH | run over, done level high, waiting for next go edge
module dp_sequencer
  import dp_sequencer_pkg::*;
#(
  parameter int unsigned INIT_CYCLES = 2,
  parameter int unsigned MAX_CYCLES  = 32'hFFFF,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             go,
  input  logic [3:0]       opcode,
  input  logic             fcode,
  input  logic             dp_done,
  output logic             dp_start,
  output logic             branch_rel_z,
  output logic             branch_rel_nz,
  output logic             branch_abs,
  output logic             reg_write_en,
  output logic             reg_sel,
  output logic             lut_in,
  output logic             mem_to_reg,
  output logic             alu_src,
  output logic             alu_sc_in,
  output logic             read_mem,
  output logic             write_mem,
  output logic [2:0]       alu_op,
  output logic             pc_hold,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int unsigned INIT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam logic [INIT_W-1:0] INIT_LOAD = INIT_W'(INIT_CYCLES - 1);
  localparam logic [INIT_W-1:0] INIT_ONE  = INIT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  // Count value seen during the last cycle a run may execute.
  localparam logic [CNT_W-1:0]  WD_LAST   = CNT_W'(MAX_CYCLES - 1);

  state_e            state_q, state_d;
  logic              go_q;
  logic [INIT_W-1:0] init_cnt_q, init_cnt_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic              timeout_q, timeout_d;

  ctrl_t dec_ctrl;
  ctrl_t ctrl;
  logic  go_rise;
  logic  wd_hit;
  logic  is_halt;
  logic  is_load;

  dp_sequencer_op_decode u_op_decode (
    .opcode_i (opcode),
    .fcode_i  (fcode),
    .ctrl_o   (dec_ctrl)
  );

  assign go_rise = go & ~go_q;
  assign wd_hit  = (cnt_q == WD_LAST);
  assign is_halt = (opcode_e'(opcode) == OP_HALT) & fcode;
  assign is_load = (opcode_e'(opcode) == OP_LW);
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_ONE;

  always_ff @(posedge CLK) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      go_q       <= 1'b0;
      init_cnt_q <= '0;
      cnt_q      <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      go_q       <= go;
      init_cnt_q <= init_cnt_d;
      cnt_q      <= cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    cnt_d      = cnt_q;
    timeout_d  = timeout_q;
    ctrl       = '0;
    dp_start   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        dp_start     = 1'b1;
        ctrl.pc_hold = 1'b1;
        if (go_rise) begin
          state_d    = ST_INIT;
          init_cnt_d = INIT_LOAD;
          cnt_d      = '0;
          timeout_d  = 1'b0;
        end
      end

      ST_INIT: begin
        dp_start     = 1'b1;
        ctrl.pc_hold = 1'b1;
        busy         = 1'b1;
        if (init_cnt_q == '0) state_d = ST_EXEC;
        else init_cnt_d = init_cnt_q - INIT_ONE;
      end

      ST_EXEC: begin
        ctrl  = dec_ctrl;
        busy  = 1'b1;
        cnt_d = cnt_inc;
        // Ending conditions outrank the load stall; strobes still issue.
        if (wd_hit) begin
          state_d   = ST_FINISH;
          timeout_d = 1'b1;
        end else if (dp_done || is_halt) begin
          state_d = ST_FINISH;
        end else if (is_load) begin
          state_d = ST_LOAD2;
        end
      end

      ST_LOAD2: begin
        ctrl.read_mem     = 1'b1;
        ctrl.mem_to_reg   = 1'b1;
        ctrl.reg_write_en = 1'b1;
        busy              = 1'b1;
        cnt_d             = cnt_inc;
        if (wd_hit) begin
          state_d   = ST_FINISH;
          timeout_d = 1'b1;
        end else if (dp_done) begin
          state_d = ST_FINISH;
        end else begin
          state_d = ST_EXEC;
        end
      end

      ST_FINISH: begin
        ctrl.pc_hold = 1'b1;
        done         = 1'b1;
        if (go_rise) begin
          state_d    = ST_INIT;
          init_cnt_d = INIT_LOAD;
          cnt_d      = '0;
          timeout_d  = 1'b0;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign branch_rel_z  = ctrl.branch_rel_z;
  assign branch_rel_nz = ctrl.branch_rel_nz;
  assign branch_abs    = ctrl.branch_abs;
  assign reg_write_en  = ctrl.reg_write_en;
  assign reg_sel       = ctrl.reg_sel;
  assign lut_in        = ctrl.lut_in;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign alu_src       = ctrl.alu_src;
  assign alu_sc_in     = ctrl.alu_sc_in;
  assign read_mem      = ctrl.read_mem;
  assign write_mem     = ctrl.write_mem;
  assign alu_op        = ctrl.alu_op;
  assign pc_hold       = ctrl.pc_hold;
  assign timeout       = timeout_q;
  assign cycle_count   = cnt_q;

endmodule

// File: tb/tb_dp_sequencer.sv
// Scoreboard bench for dp_sequencer: the driver computes every cycle's
// expected output bundle from a behavioural run model and queues it; a
// monitor on the falling edge pops and compares against the DUT.
module tb_dp_sequencer;

  localparam int INIT_C = 2;
  localparam int MAX_C  = 8;
  localparam int CW     = 16;

  logic          CLK = 1'b0;
  logic          reset, go, fcode, dp_done;
  logic [3:0]    opcode;
  logic          dp_start, branch_rel_z, branch_rel_nz, branch_abs;
  logic          reg_write_en, reg_sel, lut_in, mem_to_reg, alu_src;
  logic          alu_sc_in, read_mem, write_mem, pc_hold, busy, done, timeout;
  logic [2:0]    alu_op;
  logic [CW-1:0] cycle_count;

  always #5 CLK = ~CLK;

  dp_sequencer #(.INIT_CYCLES(INIT_C), .MAX_CYCLES(MAX_C), .CNT_W(CW)) dut (
    .CLK(CLK), .reset(reset), .go(go), .opcode(opcode), .fcode(fcode),
    .dp_done(dp_done), .dp_start(dp_start), .branch_rel_z(branch_rel_z),
    .branch_rel_nz(branch_rel_nz), .branch_abs(branch_abs),
    .reg_write_en(reg_write_en), .reg_sel(reg_sel), .lut_in(lut_in),
    .mem_to_reg(mem_to_reg), .alu_src(alu_src), .alu_sc_in(alu_sc_in),
    .read_mem(read_mem), .write_mem(write_mem), .alu_op(alu_op),
    .pc_hold(pc_hold), .busy(busy), .done(done), .timeout(timeout),
    .cycle_count(cycle_count)
  );

  // {dp_start, brz, brnz, babs, rwe, rsel, lut, m2r, asrc, asc, rm, wm,
  //  alu_op[2:0], pc_hold, busy, done, timeout, cycle_count}
  logic [34:0] act;
  assign act = {dp_start, branch_rel_z, branch_rel_nz, branch_abs, reg_write_en,
                reg_sel, lut_in, mem_to_reg, alu_src, alu_sc_in, read_mem,
                write_mem, alu_op, pc_hold, busy, done, timeout, cycle_count};

  logic [34:0] exp_q[$];
  int          id_q[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc_no = 0;

  // Instruction table
  int alu_tab[16] = '{0, 0, 1, 2, 3, 4, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0};
  bit wr_tab[16]  = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0};

  // Run model
  bit m_active, m_fin, m_load2, m_to, m_prev_go;
  int m_init_left, m_count;

  function automatic logic [34:0] model_out(logic [3:0] op, bit fc);
    bit ds = 0, brz = 0, brnz = 0, babs = 0, rwe = 0, rsel = 0, lut = 0;
    bit m2r = 0, asrc = 0, asc = 0, rm = 0, wm = 0, ph = 0, bsy = 0, dn = 0;
    logic [2:0] aop = 3'd0;
    int o = int'(op);
    if (!m_active) begin
      ph = 1;
      if (m_fin) dn = 1; else ds = 1;
    end else if (m_init_left > 0) begin
      ds = 1; ph = 1; bsy = 1;
    end else if (m_load2) begin
      rm = 1; m2r = 1; rwe = 1; bsy = 1;
    end else begin
      bsy  = 1;
      aop  = 3'(alu_tab[o]);
      rwe  = wr_tab[o];
      asrc = (o == 1);
      asc  = (o == 5 || o == 6) && fc;
      rm   = (o == 8);
      ph   = (o == 8) || (o == 15 && fc);
      wm   = (o == 9);
      brz  = (o == 10);
      brnz = (o == 11);
      babs = (o == 12);
      lut  = (o == 12) && fc;
      rsel = (o == 13);
    end
    return {ds, brz, brnz, babs, rwe, rsel, lut, m2r, asrc, asc, rm, wm, aop,
            ph, bsy, dn, m_to, 16'(m_count)};
  endfunction

  task automatic model_reset();
    m_active = 0; m_fin = 0; m_load2 = 0; m_to = 0; m_prev_go = 0;
    m_init_left = 0; m_count = 0;
  endtask

  task automatic model_step(bit rst_n, bit g, logic [3:0] op, bit fc, bit dd);
    bit rise, wd, stop;
    if (!rst_n) begin
      model_reset();
      return;
    end
    rise = g && !m_prev_go;
    m_prev_go = g;
    if (!m_active) begin
      if (rise) begin
        m_active = 1; m_fin = 0; m_load2 = 0; m_to = 0;
        m_init_left = INIT_C; m_count = 0;
      end
    end else if (m_init_left > 0) begin
      m_init_left--;
    end else begin
      wd   = (m_count == MAX_C - 1);
      stop = wd || dd || (!m_load2 && op == 4'hF && fc);
      if (m_count < 65535) m_count++;
      if (stop) begin
        m_active = 0; m_fin = 1; m_load2 = 0; m_to = wd;
      end else if (m_load2) begin
        m_load2 = 0;
      end else if (op == 4'h8) begin
        m_load2 = 1;
      end
    end
  endtask

  task automatic cyc(bit rst_n, bit g, logic [3:0] op, bit fc, bit dd);
    @(posedge CLK);
    #1;
    reset = rst_n; go = g; opcode = op; fcode = fc; dp_done = dd;
    exp_q.push_back(model_out(op, fc));
    id_q.push_back(cyc_no);
    cyc_no++;
    model_step(rst_n, g, op, fc, dd);
  endtask

  // go low for a cycle, then the rising edge, then the init window.
  task automatic start_run();
    cyc(1, 0, 4'hE, 0, 0);
    cyc(1, 1, 4'hE, 0, 0);
    for (int i = 0; i < INIT_C; i++) cyc(1, 1, 4'hE, 0, 1);
  endtask

  initial begin : monitor
    logic [34:0] e;
    int n;
    forever begin
      @(negedge CLK);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n = id_q.pop_front();
        checks++;
        if (act !== e) begin
          errors++;
          $display("FAIL outputs cycle %0d: got %h expected %h", n, act, e);
        end
      end
    end
  end

  initial begin : driver
    bit g;
    reset = 0; go = 0; opcode = 4'hE; fcode = 0; dp_done = 0;
    model_reset();

    for (int i = 0; i < 3; i++) cyc(0, 0, 4'hE, 0, 0);

    // SUB, SHL with fcode, load pair, HALT/0 continues, HALT/1 ends; go held.
    start_run();
    cyc(1, 1, 4'h2, 0, 0);
    cyc(1, 1, 4'h5, 1, 0);
    cyc(1, 1, 4'h8, 0, 0);
    cyc(1, 1, 4'h3, 1, 0);
    cyc(1, 1, 4'hF, 0, 0);
    cyc(1, 1, 4'hF, 1, 0);
    cyc(1, 1, 4'hE, 0, 0);
    cyc(1, 1, 4'hE, 0, 0);

    // Three NOPs then HALT: cycle_count 4.
    start_run();
    for (int i = 0; i < 3; i++) cyc(1, 1, 4'hE, 0, 0);
    cyc(1, 1, 4'hF, 1, 0);
    cyc(1, 1, 4'hE, 0, 0);

    // NOPs forever: watchdog after 8 executed cycles.
    start_run();
    for (int i = 0; i < 11; i++) cyc(1, 1, 4'hE, 0, 0);

    // HALT + dp_done + watchdog together.
    start_run();
    for (int i = 0; i < 7; i++) cyc(1, 1, 4'hE, 0, 0);
    cyc(1, 1, 4'hF, 1, 1);
    cyc(1, 1, 4'hE, 0, 0);

    // Reset during LOAD2, then restart; then dp_done in LOAD2.
    start_run();
    cyc(1, 1, 4'hE, 0, 0);
    cyc(1, 1, 4'h8, 0, 0);
    cyc(0, 1, 4'h8, 0, 0);
    cyc(1, 0, 4'hE, 0, 0);
    start_run();
    cyc(1, 1, 4'h8, 0, 0);
    cyc(1, 1, 4'h8, 0, 1);
    cyc(1, 1, 4'hE, 0, 0);

    // Every opcode once with both fcode values.
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < 16; k += 4) begin
        start_run();
        for (int j = k; j < k + 4; j++) begin
          if (j != 15 || f == 0) cyc(1, 1, 4'(j), f[0], 0);
          if (j == 8) cyc(1, 1, 4'hE, 0, 0);
        end
        cyc(1, 1, 4'hF, 1, 0);
      end
    end

    // Random traffic.
    g = 0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 7) == 0) g = !g;
      cyc(($urandom_range(0, 59) != 0), g, 4'($urandom_range(0, 15)),
          1'($urandom_range(0, 1)), ($urandom_range(0, 11) == 0));
    end

    @(negedge CLK);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
